cpu_core: RTL and testbench

- Single-cycle RV32I integer core with Harvard-style external memories.
- Instruction memory and data memory are outside the block: the core presents instrAddr and receives instr in the same cycle, and presents dataAddr, writeData and we with readData returned combinationally.
- Each instruction completes in one clk cycle. It is the processor block of the SoC top level.

---
 rtl/cpu_pkg.sv | 83 ++++++++
 rtl/cpu_regfile.sv | 33 +++
 rtl/cpu_core.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_core.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the single-cycle RV32I core.
// Multiply ops are only decoded when CPU_MUL_EN is defined.
package cpu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_WORD = 3'd2;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQ, ALU_NE,
    ALU_GE, ALU_GEU, ALU_MUL, ALU_MULH,
    ALU_MULHSU, ALU_MULHU
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_fmt_t;

  function automatic logic [31:0] imm_gen(
    input logic [31:0] i,
    input imm_fmt_t    fmt
  );
    logic [31:0] v;
    unique case (fmt)
      IMM_S: v = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B: v = {{19{i[31]}}, i[31], i[7],
                  i[30:25], i[11:8], 1'b0};
      IMM_U: v = {i[31:12], 12'b0};
      IMM_J: v = {{11{i[31]}}, i[31], i[19:12],
                  i[20], i[30:21], 1'b0};
      default: v = {{20{i[31]}}, i[31:20]};
    endcase
    return v;
  endfunction

  // alt selects sub/sra; callers pass it only where legal
  function automatic alu_op_t alu_from_f3(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_t op;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 31 x 32-bit register file, x0 reads zero.
// Two async read ports, one write port, sync clear.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++)
        regs[i] <= '0;
    end else if (wr_en && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0
                  : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0
                  : regs[rs2_addr];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I core with external instr/data memories.
// Define CPU_MUL_EN to add mul/mulh/mulhsu/mulhu.
module cpu_core
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] readData,
  output logic [31:0] result,
  output logic [31:0] instrAddr,
  output logic [31:0] dataAddr,
  output logic [31:0] writeData,
  output logic        we
);

  logic [31:0] pc, pc4, imm, rs1_d, rs2_d;
  logic [31:0] op_a, op_b, alu_out, wb_data, pc_next;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  alu_op_t     alu_op;
  imm_fmt_t    fmt;
  logic legal, wr, st, ld, br, jal, jalr;
  logic a_pc, a_zero, b_imm, taken;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign pc4 = pc + 32'd4;
  assign imm = imm_gen(instr, fmt);

  always_comb begin
    legal  = 1'b0;
    wr     = 1'b0;
    st     = 1'b0;
    ld     = 1'b0;
    br     = 1'b0;
    jal    = 1'b0;
    jalr   = 1'b0;
    a_pc   = 1'b0;
    a_zero = 1'b0;
    b_imm  = 1'b1;
    fmt    = IMM_I;
    alu_op = ALU_ADD;
    unique case (opc)
      OPC_LOAD: begin
        legal = (f3 == F3_WORD);
        wr    = 1'b1;
        ld    = 1'b1;
      end
      OPC_STORE: begin
        legal = (f3 == F3_WORD);
        st    = 1'b1;
        fmt   = IMM_S;
      end
      OPC_OPIMM: begin
        wr     = 1'b1;
        alu_op = alu_from_f3(f3,
                   f3 == F3_SR && instr[30]);
        unique case (f3)
          F3_SLL: legal = (f7 == F7_BASE);
          F3_SR:  legal = (f7 == F7_BASE)
                       || (f7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        wr    = 1'b1;
        b_imm = 1'b0;
        alu_op = alu_from_f3(f3, f7 == F7_ALT);
        if (f7 == F7_BASE)
          legal = 1'b1;
        else if (f7 == F7_ALT)
          legal = (f3 == F3_ADD) || (f3 == F3_SR);
`ifdef CPU_MUL_EN
        else if (f7 == F7_MUL) begin
          legal = !f3[2];
          unique case (f3[1:0])
            2'd0: alu_op = ALU_MUL;
            2'd1: alu_op = ALU_MULH;
            2'd2: alu_op = ALU_MULHSU;
            default: alu_op = ALU_MULHU;
          endcase
        end
`endif
      end
      OPC_BRANCH: begin
        br    = 1'b1;
        b_imm = 1'b0;
        fmt   = IMM_B;
        legal = 1'b1;
        unique case (f3)
          F3_BEQ:  alu_op = ALU_EQ;
          F3_BNE:  alu_op = ALU_NE;
          F3_BLT:  alu_op = ALU_SLT;
          F3_BGE:  alu_op = ALU_GE;
          F3_BLTU: alu_op = ALU_SLTU;
          F3_BGEU: alu_op = ALU_GEU;
          default: legal  = 1'b0;
        endcase
      end
      OPC_JAL: begin
        legal = 1'b1;
        wr    = 1'b1;
        jal   = 1'b1;
        a_pc  = 1'b1;
        fmt   = IMM_J;
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0);
        wr    = 1'b1;
        jalr  = 1'b1;
      end
      OPC_LUI: begin
        legal  = 1'b1;
        wr     = 1'b1;
        a_zero = 1'b1;
        fmt    = IMM_U;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        wr    = 1'b1;
        a_pc  = 1'b1;
        fmt   = IMM_U;
      end
      default: legal = 1'b0;
    endcase
  end

  assign op_a = a_zero ? '0 : (a_pc ? pc : rs1_d);
  assign op_b = b_imm ? imm : rs2_d;

`ifdef CPU_MUL_EN
  logic [63:0] p_ss, p_su, p_uu;
  assign p_ss = $signed({{32{op_a[31]}}, op_a})
              * $signed({{32{op_b[31]}}, op_b});
  assign p_su = $signed({{32{op_a[31]}}, op_a})
              * $signed({32'b0, op_b});
  assign p_uu = {32'b0, op_a} * {32'b0, op_b};
`endif

  always_comb begin
    alu_out = '0;
    unique case (alu_op)
      ALU_ADD:  alu_out = op_a + op_b;
      ALU_SUB:  alu_out = op_a - op_b;
      ALU_SLL:  alu_out = op_a << op_b[4:0];
      ALU_SLT:  alu_out = {31'b0,
                  $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_out = {31'b0, op_a < op_b};
      ALU_XOR:  alu_out = op_a ^ op_b;
      ALU_SRL:  alu_out = op_a >> op_b[4:0];
      ALU_SRA:  alu_out = $signed(op_a) >>> op_b[4:0];
      ALU_OR:   alu_out = op_a | op_b;
      ALU_AND:  alu_out = op_a & op_b;
      ALU_EQ:   alu_out = {31'b0, op_a == op_b};
      ALU_NE:   alu_out = {31'b0, op_a != op_b};
      ALU_GE:   alu_out = {31'b0,
                  $signed(op_a) >= $signed(op_b)};
      ALU_GEU:  alu_out = {31'b0, op_a >= op_b};
`ifdef CPU_MUL_EN
      ALU_MUL:    alu_out = p_ss[31:0];
      ALU_MULH:   alu_out = p_ss[63:32];
      ALU_MULHSU: alu_out = p_su[63:32];
      ALU_MULHU:  alu_out = p_uu[63:32];
`endif
      default:  alu_out = '0;
    endcase
  end

  assign taken = legal && br && alu_out[0];

  always_comb begin
    pc_next = pc4;
    if (legal && jal)
      pc_next = alu_out;
    else if (legal && jalr)
      pc_next = {alu_out[31:1], 1'b0};
    else if (taken)
      pc_next = pc + imm;
  end

  assign wb_data = ld ? readData
                 : (jal || jalr) ? pc4 : alu_out;

  always_ff @(posedge clk) begin
    if (reset)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  cpu_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (instr[19:15]),
    .rs2_addr (instr[24:20]),
    .rs1_data (rs1_d),
    .rs2_data (rs2_d),
    .wr_en    (legal && wr && !reset),
    .rd_addr  (instr[11:7]),
    .rd_data  (wb_data)
  );

  assign instrAddr = pc;
  assign result    = alu_out;
  assign dataAddr  = alu_out;
  assign writeData = rs2_d;
  assign we        = legal && st && !reset;

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: expectations queued per
// instruction, popped and compared mid-cycle.
module tb_cpu_core;
  import cpu_pkg::*;

  localparam int S_RES = 0;
  localparam int S_PC  = 1;
  localparam int S_DA  = 2;
  localparam int S_WD  = 3;
  localparam int S_WE  = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, readData;
  logic [31:0] result, instrAddr, dataAddr, writeData;
  logic        we;
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;

  cpu_core dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .readData  (readData),
    .result    (result),
    .instrAddr (instrAddr),
    .dataAddr  (dataAddr),
    .writeData (writeData),
    .we        (we)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: no summary after 200000 time units");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_PC:    return instrAddr;
      S_DA:    return dataAddr;
      S_WD:    return writeData;
      S_WE:    return {31'b0, we};
      default: return result;
    endcase
  endfunction

  task automatic want(input int sel, input string tag,
                      input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic step(input logic rst,
                      input logic [31:0] i,
                      input logic [31:0] rd);
    @(negedge clk);
    reset = rst;
    instr = i;
    readData = rd;
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.sel), e.exp);
    end
  endtask

  function automatic logic [31:0] r_t(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3,
    input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] i_t(
    input logic [31:0] im, input logic [4:0] rs1,
    input logic [2:0] f3, input logic [4:0] rd,
    input logic [6:0] op);
    return {im[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_t(
    input logic [31:0] im, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] b_t(
    input logic [31:0] im, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3,
            im[4:1], im[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] j_t(
    input logic [31:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12],
            rd, OPC_JAL};
  endfunction

  function automatic logic [31:0] u_t(
    input logic [19:0] im, input logic [4:0] rd,
    input logic [6:0] op);
    return {im, rd, op};
  endfunction

  // add x0,xr,x0 exposes xr on result without side effects
  function automatic logic [31:0] probe(input logic [4:0] r);
    return r_t(F7_BASE, 5'd0, r, F3_ADD, 5'd0);
  endfunction

  logic [31:0] sw38;
  logic [31:0] mul_x12;

  initial begin
    sw38 = s_t(32'd8, 5'd3, 5'd0, F3_WORD);
`ifdef CPU_MUL_EN
    mul_x12 = 32'hFFFF_FFFF;
`else
    mul_x12 = 32'h0;
`endif
    reset = 1'b1;
    instr = sw38;
    readData = '0;
    want(S_WE, "we_in_reset", 0);
    drain();

    step(0, i_t(0, 0, F3_WORD, 1, OPC_LOAD), 32'hDEADBEEF);
    want(S_PC, "lw_pc", 0);
    want(S_RES, "lw_res", 0);
    want(S_WE, "lw_we", 0);
    drain();

    step(0, probe(1), 0);
    want(S_PC, "pc_after_lw", 4);
    want(S_RES, "x1_loaded", 32'hDEADBEEF);
    drain();

    step(0, i_t(-5, 0, F3_ADD, 2, OPC_OPIMM), 0);
    want(S_RES, "addi_neg", 32'hFFFF_FFFB);
    drain();

    step(0, r_t(F7_BASE, 2, 2, F3_ADD, 3), 0);
    want(S_RES, "add_x2x2", 32'hFFFF_FFF6);
    drain();

    step(0, sw38, 0);
    want(S_PC, "sw_pc", 16);
    want(S_DA, "sw_addr", 8);
    want(S_WD, "sw_data", 32'hFFFF_FFF6);
    want(S_WE, "sw_we", 1);
    drain();

    step(0, b_t(-8, 0, 0, F3_BEQ), 0);
    want(S_PC, "beq_pc", 20);
    want(S_RES, "beq_cmp", 1);
    want(S_WE, "beq_we", 0);
    drain();

    step(0, b_t(12, 0, 0, F3_BNE), 0);
    want(S_PC, "beq_taken", 12);
    want(S_RES, "bne_cmp", 0);
    drain();

    step(0, j_t(20, 1), 0);
    want(S_PC, "bne_not_taken", 16);
    want(S_RES, "jal_target", 36);
    drain();

    step(0, i_t(3, 1, 3'd0, 0, OPC_JALR), 0);
    want(S_PC, "jal_pc", 36);
    want(S_RES, "jalr_sum", 23);
    drain();

    step(0, i_t(-1, 0, F3_ADD, 1, OPC_OPIMM), 0);
    want(S_PC, "jalr_pc", 22);
    drain();

    step(0, i_t(1, 0, F3_ADD, 2, OPC_OPIMM), 0);
    want(S_RES, "addi_one", 1);
    drain();

    step(0, r_t(F7_BASE, 2, 1, F3_SLT, 4), 0);
    want(S_PC, "slt_pc", 30);
    want(S_RES, "slt_signed", 1);
    drain();

    step(0, r_t(F7_BASE, 2, 1, F3_SLTU, 5), 0);
    want(S_RES, "sltu_unsigned", 0);
    drain();

    step(0, u_t(20'h80000, 6, OPC_LUI), 0);
    want(S_RES, "lui", 32'h8000_0000);
    drain();

    step(0, i_t(32'h41F, 6, F3_SR, 7, OPC_OPIMM), 0);
    want(S_RES, "srai31", 32'hFFFF_FFFF);
    drain();

    step(0, i_t(31, 6, F3_SR, 8, OPC_OPIMM), 0);
    want(S_RES, "srli31", 1);
    drain();

    step(0, r_t(F7_ALT, 1, 2, F3_ADD, 9), 0);
    want(S_RES, "sub", 2);
    drain();

    step(0, u_t(20'h00001, 10, OPC_AUIPC), 0);
    want(S_PC, "auipc_pc", 54);
    want(S_RES, "auipc", 32'h0000_1036);
    drain();

    step(0, i_t(0, 0, 3'd0, 11, OPC_LOAD), 32'h55);
    want(S_WE, "lb_we", 0);
    drain();

    step(0, probe(11), 0);
    want(S_PC, "lb_pc", 62);
    want(S_RES, "lb_no_write", 0);
    drain();

    step(0, s_t(8, 3, 0, 3'd0), 0);
    want(S_WE, "sb_we", 0);
    drain();

    step(0, r_t(F7_MUL, 2, 1, 3'd0, 12), 0);
    want(S_PC, "mul_pc", 70);
    want(S_WE, "mul_we", 0);
    drain();

    step(0, probe(12), 0);
    want(S_RES, "mul_x12", mul_x12);
    drain();

    step(1, sw38, 0);
    want(S_PC, "pre_reset_pc", 78);
    want(S_WE, "we_mid_reset", 0);
    drain();

    step(0, probe(1), 0);
    want(S_PC, "reset_pc", 0);
    want(S_RES, "x1_cleared", 0);
    drain();

    step(0, probe(3), 0);
    want(S_RES, "x3_cleared", 0);
    drain();

    step(0, i_t(5, 0, F3_ADD, 0, OPC_OPIMM), 0);
    want(S_RES, "addi_x0_res", 5);
    drain();

    step(0, probe(0), 0);
    want(S_PC, "x0_pc", 12);
    want(S_RES, "x0_zero", 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
